ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 32×8 single-port RAM. After reset it zero-fills every RAM word, because the RAM's own reset leaves contents undefined. It then grants one read or write per cycle to requester 0 or 1 and returns read data with a fixed latency and a valid strobe. It sits between the two client blocks and the RAM, and it is the only driver of the RAM's address, data and enable pins.

## Interface
Parameters:
- ADDR_W, 5, RAM address width; depth is 2**ADDR_W = 32
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- req0 / req1  in  1 each  request from requester 0 / 1
- we0 / we1  in  1 each  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W each  request address
- wdata0 / wdata1  in  DATA_W each  write data
- gnt0 / gnt1  out  1 each  combinational; command accepted this cycle
- rvalid0 / rvalid1  out  1 each  read data valid for that requester
- rdata0 / rdata1  out  DATA_W each  read data; 0 when the matching rvalid is low
- init_done  out  1  high once the zero-fill has completed
- ram_address  out  ADDR_W  registered address to the RAM
- ram_data_in  out  DATA_W  registered write data to the RAM
- ram_write_enable  out  1  registered write enable to the RAM
- ram_read_enable  out  1  registered read enable to the RAM
- ram_data_out  in  DATA_W  RAM read data; high-Z when the RAM is not reading

## Operation
- FSM states: ST_INIT, ST_RUN. Reset value is ST_INIT. ST_RUN is terminal until the next reset.
- ST_INIT:
  - Init counter c runs 0..31; each edge issues a RAM write of 0 to address c.
  - When the write to address 31 is issued, the FSM moves to ST_RUN.
  - gnt0 and gnt1 are held at 0; requests stall.
- ST_RUN:
  - gnt_i = req_i && selected by the round-robin picker.
  - If only one req is high, that requester wins.
  - If both are high, the winner is the requester not granted most recently. The pointer resets to "requester 1 was last", so requester 0 wins the first conflict.
  - The pointer updates only on a grant.
  - On the edge after a grant, ram_* are loaded from the winner's command: write_enable = we, read_enable = !we, address = addr, data_in = wdata.
  - With no grant, both enables are 0. Address and data hold their last values.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - Dropping req before gnt withdraws the request; this is legal.
  - One command is accepted per grant cycle.
  - A requester may keep req high to issue back-to-back commands.
- Read return: a 2-stage owner/valid pipe follows each granted read. rvalid_i is asserted for one cycle and rdata_i = ram_data_out in that cycle.
- Writes produce no response.
- init_done = (state == ST_RUN).

## Timing
- Reset values:
  - gnt0 = gnt1 = 0; rvalid0 = rvalid1 = 0; rdata0 = rdata1 = 0; init_done = 0.
  - ram_write_enable = ram_read_enable = 0; ram_address = 0; ram_data_in = 0.
  - c = 0; read pipe empty.
- Init sequence:
  - The first edge after reset release drives write(addr 0, data 0).
  - Write(addr 31) appears in cycle 32, and init_done rises in that same cycle.
  - The init sequence takes 32 cycles total.
- Read latency: grant in cycle N → RAM command in cycle N+1 → rvalid/rdata in cycle N+2.
- Write commit: a write granted in cycle N is in RAM at the end of cycle N+1.
- Read-after-write to the same address: a read granted the cycle after the write returns the new data.
- Throughput: one command per cycle, sustained.
- Conflicts under a continuous request from both sides alternate grants: 0, 1, 0, 1.
- Simultaneous read grant and return: the pipe handles an issue and a return in the same cycle with no bubble.
- Reset mid-operation:
  - In-flight reads are dropped with no rvalid.
  - In-flight writes may or may not have committed.
  - The FSM restarts in ST_INIT and the zero-fill reruns.
- Address wrap is not applicable: the init counter stops at 31 and does not wrap.

## Structure
- Package ram_arbiter_pkg holds:
  - state_t enum {ST_INIT, ST_RUN}
  - NREQ = 2
  - DEPTH = 2**ADDR_W
- Sub-module rr_arb2: a combinational 2-way round-robin picker plus a last-grant pointer register. It takes req[1:0] and returns gnt[1:0].
- The top level contains the FSM, init counter, RAM command registers and the read-owner pipe.

## Test plan
- Reset, then idle: init_done stays low for cycles 1..31 and is high from cycle 32. ram_address steps 0..31 with ram_write_enable = 1 and ram_data_in = 0. After init, a read of every address returns 0.
- req0 write 0xA5 to addr 3 in cycle N; req0 read addr 3 in cycle N+1 → gnt0 in N and N+1; rvalid0 in N+3 with rdata0 = 0xA5; rvalid1 never asserted.
- Both requesters continuously read addresses 7 and 9 (holding 0x11 and 0x22) → grants alternate 0, 1, 0, 1. Each rvalid returns its own data two cycles after its grant, with no cross-delivery.
- req1 raised during ST_INIT → gnt1 is held low until init_done. The grant arrives in cycle 32 and the data returns in cycle 34.
- Reset asserted in the cycle after a granted read → no rvalid appears. All outputs return to their reset values immediately and the zero-fill restarts.
- Write 0xFF to addr 31, then read it back → rdata = 0xFF. rdata0 and rdata1 are 0 in every cycle where rvalid is low, even though ram_data_out is Z.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arbiter_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int NREQ          = 2;
   localparam int ADDR_W_DEFAULT = 5;
   localparam int DEPTH         = 2 ** ADDR_W_DEFAULT;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer remembers which requester won last.
module rr_arb2
   import ram_arbiter_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt
);

   logic last_r;   // 1 = requester 1 was granted most recently

   // grant decode: a lone request wins, a conflict goes to the one not served last
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end else begin
         gnt = 2'b00;
      end
   end

   // last-grant pointer, moves only when something is granted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_r <= 1'b1;
      end else if (|gnt) begin
         last_r <= gnt[1];
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Zero-fills the RAM after reset, then arbitrates two requesters onto it and
// returns read data two cycles after the grant.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              init_done,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_write_enable,
   output logic              ram_read_enable,
   input  logic [DATA_W-1:0] ram_data_out
);

   state_t            state_r;
   logic [ADDR_W-1:0] cnt_r;
   logic [NREQ-1:0]   gnt_s;
   logic              run_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              p1_valid_r;
   logic              p1_owner_r;
   logic              p2_valid_r;
   logic              p2_owner_r;

   assign run_s     = (state_r == ST_RUN);
   assign init_done = run_s;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (run_s),
      .req   ({req1, req0}),
      .gnt   (gnt_s)
   );

   assign gnt0 = gnt_s[0];
   assign gnt1 = gnt_s[1];

   // winner command mux
   always_comb begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
      if (gnt_s[1]) begin
         sel_we_s    = we1;
         sel_addr_s  = addr1;
         sel_wdata_s = wdata1;
      end else begin
         sel_we_s    = we0;
         sel_addr_s  = addr0;
         sel_wdata_s = wdata0;
      end
   end

   // sequencer FSM: zero-fill walk, then registered RAM command from the winner
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r          <= ST_INIT;
         cnt_r            <= {ADDR_W{1'b0}};
         ram_address      <= {ADDR_W{1'b0}};
         ram_data_in      <= {DATA_W{1'b0}};
         ram_write_enable <= 1'b0;
         ram_read_enable  <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               ram_address      <= cnt_r;
               ram_data_in      <= {DATA_W{1'b0}};
               ram_write_enable <= 1'b1;
               ram_read_enable  <= 1'b0;
               if (cnt_r == {ADDR_W{1'b1}}) begin
                  state_r <= ST_RUN;
               end else begin
                  cnt_r <= cnt_r + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               if (|gnt_s) begin
                  ram_address      <= sel_addr_s;
                  ram_data_in      <= sel_wdata_s;
                  ram_write_enable <= sel_we_s;
                  ram_read_enable  <= !sel_we_s;
               end else begin
                  ram_write_enable <= 1'b0;
                  ram_read_enable  <= 1'b0;
               end
            end
            default: begin
               state_r          <= ST_INIT;
               ram_write_enable <= 1'b0;
               ram_read_enable  <= 1'b0;
            end
         endcase
      end
   end

   // read-owner pipe: stage 1 lines up with the RAM command, stage 2 with its data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p1_valid_r <= 1'b0;
         p1_owner_r <= 1'b0;
         p2_valid_r <= 1'b0;
         p2_owner_r <= 1'b0;
      end else begin
         p1_valid_r <= (|gnt_s) && !sel_we_s;
         p1_owner_r <= gnt_s[1];
         p2_valid_r <= p1_valid_r;
         p2_owner_r <= p1_owner_r;
      end
   end

   assign rvalid0 = p2_valid_r && !p2_owner_r;
   assign rvalid1 = p2_valid_r && p2_owner_r;
   assign rdata0  = rvalid0 ? ram_data_out : {DATA_W{1'b0}};
   assign rdata1  = rvalid1 ? ram_data_out : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [4:0] addr0 = 5'd0, addr1 = 5'd0;
   logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
   logic       gnt0, gnt1, rvalid0, rvalid1, init_done;
   logic [7:0] rdata0, rdata1;
   logic [4:0] ram_address;
   logic [7:0] ram_data_in;
   logic       ram_write_enable, ram_read_enable;
   wire  [7:0] ram_data_out;

   typedef struct {
      bit         owner;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc;

   logic [7:0] mem [DEPTH];
   logic [7:0] rd_q;
   logic       rd_act;

   ram_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .init_done(init_done),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
      .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   // single-port RAM: one-cycle read, output floats when not reading
   initial begin
      rd_act = 1'b0;
      rd_q   = 8'h00;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i) ^ 8'h5A;
   end

   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      if (ram_read_enable) rd_q <= mem[ram_address];
      rd_act <= ram_read_enable;
   end

   assign ram_data_out = rd_act ? rd_q : 8'hzz;

   // cycle number k = after the k-th rising edge since reset release
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // read-return monitor
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL rvalid_timeout: got no return expected owner %0d data %0h at cycle %0d", sb[0].owner, sb[0].data, sb[0].due);
         void'(sb.pop_front());
      end
      chk("rvalid_both", {31'd0, rvalid0 & rvalid1}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         logic       rv;
         logic [7:0] rd;
         rv = (i == 0) ? rvalid0 : rvalid1;
         rd = (i == 0) ? rdata0 : rdata1;
         if (rv) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rvalid_unexpected: got rvalid%0d data %0h expected none", i, rd);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rvalid_owner", i, {31'd0, e.owner});
               chk("rdata", {24'd0, rd}, {24'd0, e.data});
               chk("rvalid_cycle", cyc, e.due);
            end
         end else begin
            chk("rdata_idle_zero", {24'd0, rd}, 32'd0);
         end
      end
   end

   task automatic step(input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [4:0] a1, input logic [7:0] d1,
                       input logic eg0, input logic eg1, input logic [7:0] e0, input logic [7:0] e1);
      @(posedge clk); #1;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clk);
      chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
      chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
      if (eg0 && !w0) sb.push_back('{owner: 1'b0, data: e0, due: cyc + 2});
      if (eg1 && !w1) sb.push_back('{owner: 1'b1, data: e1, due: cyc + 2});
   endtask

   task automatic run_init(input bit with_req1);
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         if (k == 1 && with_req1) begin
            req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
         end
         @(negedge clk);
         chk("init_we", {31'd0, ram_write_enable}, 32'd1);
         chk("init_re", {31'd0, ram_read_enable}, 32'd0);
         chk("init_addr", {27'd0, ram_address}, k - 1);
         chk("init_data", {24'd0, ram_data_in}, 32'd0);
         chk("init_done", {31'd0, init_done}, (k == 32) ? 32'd1 : 32'd0);
         chk("init_gnt0", {31'd0, gnt0}, 32'd0);
         chk("init_gnt1", {31'd0, gnt1}, (with_req1 && k == 32) ? 32'd1 : 32'd0);
         if (with_req1 && k == 32) sb.push_back('{owner: 1'b1, data: 8'h00, due: 34});
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_ram_en", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
      chk("rst_ram_addr", {27'd0, ram_address}, 32'd0);
      chk("rst_ram_din", {24'd0, ram_data_in}, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      reset = 1'b1;

      // zero-fill with requester 1 waiting from cycle 1
      run_init(1'b1);
      step(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, 0,0, 8'h00,8'h00);
      chk("run_re_after_init_gnt", {31'd0, ram_read_enable}, 32'd1);
      chk("run_addr_after_init_gnt", {27'd0, ram_address}, 32'd5);

      // every word reads back as zero, back to back
      for (int i = 0; i < 32; i++)
         step(1,0,5'(i),8'h00, 0,0,5'd0,8'h00, 1,0, 8'h00,8'h00);

      // write then immediate read of the same address
      step(1,1,5'd3,8'hA5, 0,0,5'd0,8'h00, 1,0, 8'h00,8'h00);
      step(1,0,5'd3,8'h00, 0,0,5'd0,8'h00, 1,0, 8'hA5,8'h00);

      // seed 7 and 9, then both read continuously: grants alternate 0,1,0,1
      step(1,1,5'd7,8'h11, 0,0,5'd0,8'h00, 1,0, 8'h00,8'h00);
      step(0,0,5'd0,8'h00, 1,1,5'd9,8'h22, 0,1, 8'h00,8'h00);
      step(1,0,5'd7,8'h00, 1,0,5'd9,8'h00, 1,0, 8'h11,8'h22);
      step(1,0,5'd7,8'h00, 1,0,5'd9,8'h00, 0,1, 8'h11,8'h22);
      step(1,0,5'd7,8'h00, 1,0,5'd9,8'h00, 1,0, 8'h11,8'h22);
      step(1,0,5'd7,8'h00, 1,0,5'd9,8'h00, 0,1, 8'h11,8'h22);

      // top address write/read-back
      step(0,0,5'd0,8'h00, 1,1,5'd31,8'hFF, 0,1, 8'h00,8'h00);
      step(0,0,5'd0,8'h00, 1,0,5'd31,8'h00, 0,1, 8'h00,8'hFF);
      repeat (4) step(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, 0,0, 8'h00,8'h00);
      chk("sb_drained_1", sb.size(), 32'd0);

      // reset one cycle after a granted read: the return is dropped
      step(1,0,5'd3,8'h00, 0,0,5'd0,8'h00, 1,0, 8'hA5,8'h00);
      @(posedge clk); #1;
      req0 = 1'b0;
      reset = 1'b0;
      sb.delete();
      #1;
      chk_reset_outputs();
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      reset = 1'b1;

      // zero-fill reruns, so the earlier 0xA5 is gone
      run_init(1'b0);
      step(1,0,5'd3,8'h00, 0,0,5'd0,8'h00, 1,0, 8'h00,8'h00);
      step(0,0,5'd0,8'h00, 1,0,5'd31,8'h00, 0,1, 8'h00,8'h00);
      repeat (4) step(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, 0,0, 8'h00,8'h00);
      chk("sb_drained_2", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
